// File: rtl/fpu_pkg.sv
// Shared FPU types and format constants: status codes, field widths, default bias,
// and the encoder's sequencing states.
`timescale 1ns/1ps
package fpu_pkg;

    localparam int EXP_W            = 10;
    localparam int FRAC_W           = 21;
    localparam int DEFAULT_EXP_BIAS = 511;

    typedef enum logic [3:0] {
        OVERFLOW,
        UNDERFLOW,
        EXACT,
        INEXACT
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_NORMALIZE,
        S_ROUND,
        S_PACK
    } enc_state_t;

endpackage

// File: rtl/int_to_fpu_encoder_if.sv
// Start/busy/valid request bus between an integer producer and int_to_fpu_encoder.
`timescale 1ns/1ps
interface int_to_fpu_encoder_if;
  import fpu_pkg::*;

  logic        start;
  logic [31:0] data_in;
  logic        busy;
  logic        valid;
  logic [31:0] data_out;
  status_t     status_out;

  modport master (
    output start, data_in,
    input  busy, valid, data_out, status_out
  );

  modport slave (
    input  start, data_in,
    output busy, valid, data_out, status_out
  );

endinterface

// File: rtl/fpu_round_unit.sv
// Combinational rounding of a normalized fraction; nearest-even when ROUND_NEAREST_EN
// is defined, truncation otherwise. Inexact is reported identically in both builds.
`timescale 1ns/1ps
module fpu_round_unit
  import fpu_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic              guard,
  input  logic              sticky,
  input  logic [EXP_W-1:0]  exp,
  output logic [FRAC_W-1:0] frac_rnd,
  output logic [EXP_W-1:0]  exp_rnd,
  output logic              inexact
);

`ifdef ROUND_NEAREST_EN
  logic            round_up;
  logic [FRAC_W:0] frac_sum;

  assign round_up = guard & (sticky | frac[0]);
  assign frac_sum = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
  // Carry out of an all-ones fraction bumps the exponent; the fraction wraps to zero.
  assign frac_rnd = frac_sum[FRAC_W-1:0];
  assign exp_rnd  = exp + {{(EXP_W-1){1'b0}}, frac_sum[FRAC_W]};
`else
  assign frac_rnd = frac;
  assign exp_rnd  = exp;
`endif

  assign inexact = guard | sticky;

endmodule

// File: rtl/int_to_fpu_encoder.sv
// Iterative int32 -> float converter (one normalization shift per cycle).
// Optional build macro ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
`timescale 1ns/1ps
module int_to_fpu_encoder
  import fpu_pkg::*;
#(
  parameter int EXP_BIAS = DEFAULT_EXP_BIAS
) (
  input  logic                 clock_100Khz,
  input  logic                 reset,
  int_to_fpu_encoder_if.slave  bus
);

  enc_state_t        state_reg;
  logic [31:0]       data_reg;
  logic              sign_reg;
  logic [31:0]       mag_reg;
  logic [4:0]        k_reg;
  logic [FRAC_W-1:0] frac_reg;
  logic [EXP_W-1:0]  exp_reg;
  logic              inexact_reg;
  logic              busy_reg;
  logic              valid_reg;
  logic [31:0]       data_out_reg;
  status_t           status_reg;

  logic [31:0]       abs_mag;
  logic [EXP_W-1:0]  exp_calc;
  logic [FRAC_W-1:0] frac_rnd;
  logic [EXP_W-1:0]  exp_rnd;
  logic              inexact_rnd;

  // Two's-complement negate also maps -2^31 onto 0x80000000 as an unsigned magnitude.
  assign abs_mag  = data_reg[31] ? (~data_reg + 32'd1) : data_reg;
  assign exp_calc = EXP_W'(EXP_BIAS + 31 - int'(k_reg));

  fpu_round_unit u_round (
    .frac     (mag_reg[30:10]),
    .guard    (mag_reg[9]),
    .sticky   (|mag_reg[8:0]),
    .exp      (exp_calc),
    .frac_rnd (frac_rnd),
    .exp_rnd  (exp_rnd),
    .inexact  (inexact_rnd)
  );

  always_ff @(posedge clock_100Khz) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      data_reg     <= '0;
      sign_reg     <= 1'b0;
      mag_reg      <= '0;
      k_reg        <= '0;
      frac_reg     <= '0;
      exp_reg      <= '0;
      inexact_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      data_out_reg <= '0;
      status_reg   <= EXACT;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            data_reg  <= bus.data_in;
            busy_reg  <= 1'b1;
            state_reg <= S_ABS;
          end
        end
        S_ABS: begin
          sign_reg <= data_reg[31];
          mag_reg  <= abs_mag;
          k_reg    <= '0;
          if (abs_mag == 32'd0) begin
            frac_reg    <= '0;
            exp_reg     <= '0;
            inexact_reg <= 1'b0;
            state_reg   <= S_PACK;
          end else begin
            state_reg <= S_NORMALIZE;
          end
        end
        S_NORMALIZE: begin
          if (mag_reg[31]) begin
            state_reg <= S_ROUND;
          end else begin
            mag_reg <= mag_reg << 1;
            k_reg   <= k_reg + 5'd1;
          end
        end
        S_ROUND: begin
          frac_reg    <= frac_rnd;
          exp_reg     <= exp_rnd;
          inexact_reg <= inexact_rnd;
          state_reg   <= S_PACK;
        end
        S_PACK: begin
          data_out_reg <= {sign_reg, exp_reg, frac_reg};
          status_reg   <= inexact_reg ? INEXACT : EXACT;
          valid_reg    <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= S_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.valid      = valid_reg;
  assign bus.data_out   = data_out_reg;
  assign bus.status_out = status_reg;

endmodule

// File: tb/tb_int_to_fpu_encoder.sv
// Self-checking bench for int_to_fpu_encoder: directed table, control corner cases,
// and random operands against an arithmetic reference model.
`timescale 1ns/1ps
module tb_int_to_fpu_encoder;
  import fpu_pkg::*;

  logic clock_100Khz = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  int_to_fpu_encoder_if bus();

  int_to_fpu_encoder dut (
    .clock_100Khz (clock_100Khz),
    .reset        (reset),
    .bus          (bus)
  );

  always #5 clock_100Khz = ~clock_100Khz;

  typedef struct {
    logic [31:0] din;
    logic [31:0] word;
    status_t     st;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: value = m = 1.f * 2^p, so frac = m scaled to 21 bits below its MSB.
  function automatic void ref_model(input logic [31:0] x, output logic [31:0] word,
                                    output status_t st, output int lat);
    longint v, m, q, rem, unit;
    int p;
    logic [EXP_W-1:0] e;
    v = longint'($signed(x));
    m = (v < 0) ? -v : v;
    word = 32'd0;
    st   = EXACT;
    lat  = 2;
    if (m == 0) return;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    if (p > FRAC_W) begin
      unit = longint'(1) << (p - FRAC_W);
      q    = m >> (p - FRAC_W);
      rem  = m - q * unit;
    end else begin
      unit = 1;
      q    = m << (FRAC_W - p);
      rem  = 0;
    end
    e = EXP_W'(DEFAULT_EXP_BIAS + p);
`ifdef ROUND_NEAREST_EN
    if ((2 * rem > unit) || ((2 * rem == unit) && q[0])) q++;
    if (q == (longint'(1) << (FRAC_W + 1))) begin
      q = longint'(1) << FRAC_W;
      e++;
    end
`endif
    word = {x[31], e, q[FRAC_W-1:0]};
    st   = (rem != 0) ? INEXACT : EXACT;
    lat  = 35 - p;
  endfunction

  // Issue one request and wait (bounded) for its valid pulse.
  task automatic run_op(input logic [31:0] x, output logic [31:0] word, output status_t st,
                        output int lat, output logic busy_ok);
    @(negedge clock_100Khz);
    bus.start   = 1'b1;
    bus.data_in = x;
    @(posedge clock_100Khz);
    #1;
    bus.start   = 1'b0;
    bus.data_in = $urandom;
    busy_ok = bus.busy;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock_100Khz);
      #1;
      if (bus.valid) begin
        lat = i;
        break;
      end
    end
    word = bus.data_out;
    st   = bus.status_out;
    busy_ok = busy_ok & ~bus.busy & (lat != 0);
    $display("[TB] op data_in=0x%08h data_out=0x%08h status=%0d latency=%0d", x, word, st, lat);
  endtask

  initial begin
    logic [31:0] word, x, exp_word;
    status_t     st, exp_st;
    int          lat, exp_lat, cnt, first_lat;
    logic        busy_ok;

    vecs[0] = '{32'h0000_0001, 32'h3FE0_0000, EXACT, 35};
    vecs[1] = '{32'hFFFF_FFFF, 32'hBFE0_0000, EXACT, 35};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, EXACT, 2};
    vecs[3] = '{32'h0000_0003, 32'h4010_0000, EXACT, 34};
    vecs[4] = '{32'h8000_0000, 32'hC3C0_0000, EXACT, 4};
`ifdef ROUND_NEAREST_EN
    vecs[5] = '{32'h7FFF_FFFF, 32'h43C0_0000, INEXACT, 5};
`else
    vecs[5] = '{32'h7FFF_FFFF, 32'h43BF_FFFF, INEXACT, 5};
`endif
    vecs[6] = '{32'hFFFF_FFFD, 32'hC010_0000, EXACT, 34};

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = 32'd0;
    repeat (2) @(posedge clock_100Khz);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_data_out", bus.data_out, 32'd0);
    check("reset_status", 32'(bus.status_out), 32'(EXACT));
    @(negedge clock_100Khz);
    reset = 1'b0;

    // Directed table; consecutive calls also exercise start in the valid cycle.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].din, word, st, lat, busy_ok);
      check($sformatf("vec%0d_data", i), word, vecs[i].word);
      check($sformatf("vec%0d_status", i), 32'(st), 32'(vecs[i].st));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy", i), 32'(busy_ok), 32'd1);
    end

    // Reset in the middle of NORMALIZE.
    @(negedge clock_100Khz);
    bus.start   = 1'b1;
    bus.data_in = 32'd1;
    @(posedge clock_100Khz);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clock_100Khz);
    @(negedge clock_100Khz);
    reset = 1'b1;
    @(posedge clock_100Khz);
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_valid", 32'(bus.valid), 32'd0);
    check("midreset_data_out", bus.data_out, 32'd0);
    check("midreset_status", 32'(bus.status_out), 32'(EXACT));
    @(negedge clock_100Khz);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clock_100Khz);
      #1;
      if (bus.valid) cnt++;
    end
    check("midreset_no_valid", 32'(cnt), 32'd0);
    $display("[TB] op mid-operation reset, valid pulses afterwards=%0d", cnt);

    // start pulses while busy must be ignored.
    @(negedge clock_100Khz);
    bus.start   = 1'b1;
    bus.data_in = 32'd3;
    @(posedge clock_100Khz);
    #1;
    bus.start = 1'b0;
    cnt = 0;
    first_lat = 0;
    word = 32'd0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clock_100Khz);
      bus.start   = (i == 3 || i == 10);
      bus.data_in = 32'd0;
      @(posedge clock_100Khz);
      #1;
      if (bus.valid) begin
        cnt++;
        if (first_lat == 0) begin
          first_lat = i;
          word = bus.data_out;
        end
      end
    end
    bus.start = 1'b0;
    check("busy_start_pulses", 32'(cnt), 32'd1);
    check("busy_start_latency", 32'(first_lat), 32'd34);
    check("busy_start_data", word, 32'h4010_0000);
    $display("[TB] op start-while-busy, valid pulses=%0d latency=%0d data_out=0x%08h", cnt, first_lat, word);

    // Random operands across all magnitudes and signs.
    for (int i = 0; i < 150; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = -x;
      ref_model(x, exp_word, exp_st, exp_lat);
      run_op(x, word, st, lat, busy_ok);
      check($sformatf("rand%0d_data", i), word, exp_word);
      check($sformatf("rand%0d_status", i), 32'(st), 32'(exp_st));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(exp_lat));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
